// File: rtl/mmcm_drp_reconfig_if.sv
// Configuration stream and DRP bus between the reconfiguration initiator (slave)
// and its environment: the entry producer plus the MMCM DRP port (master).
interface mmcm_drp_reconfig_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic        cfg_last;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, drp_do, drp_drdy,
        input  cfg_ready, drp_daddr, drp_di, drp_den, drp_dwe
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, drp_do, drp_drdy,
        output cfg_ready, drp_daddr, drp_di, drp_den, drp_dwe
    );
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// Applies a stream of masked register updates to the MMCM DRP port as
// read-modify-writes while the MMCM is held in reset, then waits for lock.
module mmcm_drp_reconfig #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int RST_HOLD     = 4
) (
    input  logic               clock,
    input  logic               reset,
    mmcm_drp_reconfig_if.slave bus,
    output logic               mmcm_rst,
    input  logic               mmcm_locked,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int MAX_DT = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
    localparam int MAX_T  = (LOCK_TIMEOUT > MAX_DT) ? LOCK_TIMEOUT : MAX_DT;
    localparam int CW     = $clog2(MAX_T) + 1;

    typedef enum logic [2:0] {
        IDLE, HOLD, ENTRY, READ, READ_WAIT, WRITE, WRITE_WAIT, WAIT_LOCK
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic          cnt_clear, do_abort, do_done;
    logic [6:0]    daddr_q;
    logic [15:0]   di_q, mask_q, data_q;
    logic          den_q, dwe_q, last_q;
    logic          locked_meta, locked_sync;

    assign bus.cfg_ready = (state == ENTRY);
    assign bus.drp_daddr = daddr_q;
    assign bus.drp_di    = di_q;
    assign bus.drp_den   = den_q;
    assign bus.drp_dwe   = dwe_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Timeouts fire on the last allowed cycle so the registered error pulse
    // lands exactly the timeout length after the wait state was entered.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        do_abort   = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_valid) begin
                    next_state = HOLD;
                    cnt_clear  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(RST_HOLD - 1)) next_state = ENTRY;
            end
            ENTRY: begin
                if (bus.cfg_valid) next_state = READ;
            end
            READ: begin
                next_state = READ_WAIT;
                cnt_clear  = 1'b1;
            end
            READ_WAIT: begin
                if (bus.drp_drdy) begin
                    next_state = WRITE;
                end else if (cnt == CW'(DRDY_TIMEOUT - 1)) begin
                    next_state = IDLE;
                    do_abort   = 1'b1;
                end
            end
            WRITE: begin
                next_state = WRITE_WAIT;
                cnt_clear  = 1'b1;
            end
            WRITE_WAIT: begin
                if (bus.drp_drdy) begin
                    if (last_q) begin
                        next_state = WAIT_LOCK;
                        cnt_clear  = 1'b1;
                    end else begin
                        next_state = ENTRY;
                    end
                end else if (cnt == CW'(DRDY_TIMEOUT - 1)) begin
                    next_state = IDLE;
                    do_abort   = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    next_state = IDLE;
                    do_done    = 1'b1;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    next_state = IDLE;
                    do_abort   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            mmcm_rst    <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= mmcm_locked;
            locked_sync <= locked_meta;
            den_q       <= (next_state == READ) || (next_state == WRITE);
            dwe_q       <= (next_state == WRITE);
            done        <= do_done;
            error       <= do_abort;

            if (cnt_clear)
                cnt <= '0;
            else if (state inside {HOLD, READ_WAIT, WRITE_WAIT, WAIT_LOCK})
                cnt <= cnt + 1'b1;

            // MMCM reset spans the whole entry stream, never pulsed between entries.
            if (state == IDLE && next_state == HOLD)
                mmcm_rst <= 1'b1;
            else if (do_abort || (state == WRITE_WAIT && next_state == WAIT_LOCK))
                mmcm_rst <= 1'b0;

            if (state == ENTRY && bus.cfg_valid) begin
                daddr_q <= bus.cfg_addr;
                mask_q  <= bus.cfg_mask;
                data_q  <= bus.cfg_data;
                last_q  <= bus.cfg_last;
            end

            if (state == READ_WAIT && bus.drp_drdy)
                di_q <= (bus.drp_do & mask_q) | (bus.cfg_data & 16'h0000) | (data_q & ~mask_q);
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Randomized and directed bench: a DRP register-file responder plus a plain
// read-modify-write reference model over an array of MMCM registers.
module tb_mmcm_drp_reconfig;

    localparam int DRDY_TO = 16;
    localparam int LOCK_TO = 200;
    localparam int HOLD    = 4;

    logic clock = 1'b0;
    logic reset;
    logic mmcm_rst, mmcm_locked, busy, done, error;

    mmcm_drp_reconfig_if bus();

    mmcm_drp_reconfig #(
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO),
        .RST_HOLD     (HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DRP register file seen by the DUT, and the reference copy
    logic [15:0] mem [128];
    logic [15:0] ref_mem [128];
    int          resp_lat = 1;
    bit          resp_enable = 1'b1;
    int          pend = 0;
    logic [6:0]  pend_addr;
    logic        pend_we;
    logic [15:0] pend_di;
    logic        resp_drdy = 1'b0, spur_drdy = 1'b0;
    logic [15:0] resp_do = '0, spur_do = '0;

    assign bus.drp_drdy = resp_drdy | spur_drdy;
    assign bus.drp_do   = spur_drdy ? spur_do : resp_do;

    logic [6:0]  log_addr [$];
    logic        log_we [$];
    logic [15:0] log_di [$];
    int          log_cyc [$];
    logic        log_rst [$];
    logic        log_rdy [$];

    always @(negedge clock) begin
        resp_drdy = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                if (pend_we) mem[pend_addr] = pend_di;
                else         resp_do = mem[pend_addr];
                resp_drdy = 1'b1;
            end
        end
        if (bus.drp_den === 1'b1) begin
            log_addr.push_back(bus.drp_daddr);
            log_we.push_back(bus.drp_dwe);
            log_di.push_back(bus.drp_di);
            log_cyc.push_back(cyc);
            log_rst.push_back(mmcm_rst);
            log_rdy.push_back(bus.cfg_ready);
            if (resp_enable) begin
                pend      = resp_lat;
                pend_addr = bus.drp_daddr;
                pend_we   = bus.drp_dwe;
                pend_di   = bus.drp_di;
            end
        end
    end

    int   rst_rise_cyc = -1;
    int   rst_fall_cnt = 0;
    int   done_cnt = 0;
    int   both_cnt = 0;
    logic rst_prev = 1'b0;

    always @(negedge clock) begin
        if (mmcm_rst === 1'b1 && rst_prev !== 1'b1) rst_rise_cyc = cyc;
        if (mmcm_rst === 1'b0 && rst_prev === 1'b1) rst_fall_cnt++;
        if (done === 1'b1) done_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        rst_prev = mmcm_rst;
    end

    logic [6:0]  seq_addr [8];
    logic [15:0] seq_mask [8];
    logic [15:0] seq_data [8];
    int          hs_cyc [8];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelApply(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        logic [15:0] nv;
        nv = (ref_mem[a] & m) | (d & ~m);
        ref_mem[a] = nv;
        return nv;
    endfunction

    task automatic sendEntry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                             input logic last, output int rc);
        int n;
        bus.cfg_addr  = a;
        bus.cfg_mask  = m;
        bus.cfg_data  = d;
        bus.cfg_last  = last;
        bus.cfg_valid = 1'b1;
        n = 0;
        while (bus.cfg_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput("handshake", bus.cfg_ready, 1'b1);
        rc = cyc;
        @(negedge clock);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic finishLock(input int lock_delay);
        int n, rel, lk, d0;
        d0 = done_cnt;
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        checkOutput("release", mmcm_rst, 1'b0);
        rel = cyc;
        if (log_cyc.size() > 0)
            checkOutput("release_time", rel - log_cyc[log_cyc.size()-1], resp_lat + 1);
        repeat (lock_delay) @(negedge clock);
        mmcm_locked = 1'b1;
        lk = cyc;
        repeat (2) @(negedge clock);
        checkOutput("done_early", done, 1'b0);
        checkOutput("busy_wait_lock", busy, 1'b1);
        @(negedge clock);
        checkOutput("done_pulse_time", cyc - lk, 3);
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("busy_after_done", busy, 1'b0);
        checkOutput("no_error_with_done", error, 1'b0);
        @(negedge clock);
        checkOutput("done_one_cycle", done, 1'b0);
        mmcm_locked = 1'b0;
        checkOutput("done_count", done_cnt - d0, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic checkLog(input int base, input int n);
        int r, w;
        logic [15:0] exp;
        checkOutput("log_len", log_addr.size() - base, 2 * n);
        for (int i = 0; i < n; i++) begin
            exp = modelApply(seq_addr[i], seq_mask[i], seq_data[i]);
            r = base + 2 * i;
            w = r + 1;
            if (w < log_addr.size()) begin
                checkOutput("rd_addr", log_addr[r], seq_addr[i]);
                checkOutput("rd_we", log_we[r], 1'b0);
                checkOutput("wr_addr", log_addr[w], seq_addr[i]);
                checkOutput("wr_we", log_we[w], 1'b1);
                checkOutput("wr_di", log_di[w], exp);
                checkOutput("rd_time", log_cyc[r] - hs_cyc[i], 1);
                checkOutput("wr_time", log_cyc[w] - log_cyc[r], resp_lat + 1);
                checkOutput("rst_at_rd", log_rst[r], 1'b1);
                checkOutput("rst_at_wr", log_rst[w], 1'b1);
                checkOutput("ready_low", log_rdy[r] | log_rdy[w], 1'b0);
            end
        end
    endtask

    task automatic applyStimulus(input int n, input int gap, input int lock_delay);
        int base, start, rc, f0;
        base  = log_addr.size();
        f0    = rst_fall_cnt;
        start = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) @(negedge clock);
            sendEntry(seq_addr[i], seq_mask[i], seq_data[i], (i == n - 1), rc);
            hs_cyc[i] = rc;
        end
        checkOutput("ready_rise", hs_cyc[0] - start, HOLD + 1);
        checkOutput("rst_rise", rst_rise_cyc - start, 1);
        finishLock(lock_delay);
        checkLog(base, n);
        checkOutput("rst_continuous", rst_fall_cnt - f0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, gap, lk, base, rc, c, w, rel, d0;
        logic [6:0] a0, a1;

        reset = 1'b1;
        mmcm_locked = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_mask = '0;
        bus.cfg_data = '0;
        bus.cfg_last = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clock);
        checkOutput("rst_cfg_ready", bus.cfg_ready, 1'b0);
        checkOutput("rst_den", bus.drp_den, 1'b0);
        checkOutput("rst_dwe", bus.drp_dwe, 1'b0);
        checkOutput("rst_daddr", bus.drp_daddr, 7'h0);
        checkOutput("rst_di", bus.drp_di, 16'h0);
        checkOutput("rst_mmcm_rst", mmcm_rst, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Nominal single entry
        mem[8] = 16'hFFFF;
        ref_mem[8] = 16'hFFFF;
        resp_lat = 3;
        seq_addr[0] = 7'h08; seq_mask[0] = 16'h1000; seq_data[0] = 16'h0145;
        base = log_addr.size();
        applyStimulus(1, 0, 10);
        if (log_di.size() > base + 1) checkOutput("nominal_di", log_di[base+1], 16'h1145);

        // Three-entry stream with gaps
        resp_lat = 2;
        seq_addr[0] = 7'h08; seq_addr[1] = 7'h09; seq_addr[2] = 7'h16;
        for (int i = 0; i < 3; i++) begin
            seq_mask[i] = 16'($urandom);
            seq_data[i] = 16'($urandom);
        end
        applyStimulus(3, 5, 7);

        // Random streams
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                seq_addr[i] = 7'($urandom_range(0, 127));
                seq_mask[i] = 16'($urandom);
                seq_data[i] = 16'($urandom);
            end
            gap = $urandom_range(0, 5);
            lk  = $urandom_range(1, 20);
            resp_lat = $urandom_range(1, 4);
            applyStimulus(n, gap, lk);
        end

        // Spurious drdy in ENTRY, then full-preserve mask
        a0 = 7'($urandom_range(64, 95));
        a1 = 7'($urandom_range(32, 63));
        mem[a1] = 16'hA5C3;
        ref_mem[a1] = 16'hA5C3;
        resp_lat = 2;
        seq_addr[0] = a0; seq_mask[0] = 16'($urandom); seq_data[0] = 16'($urandom);
        seq_addr[1] = a1; seq_mask[1] = 16'hFFFF;      seq_data[1] = 16'($urandom);
        base = log_addr.size();
        sendEntry(seq_addr[0], seq_mask[0], seq_data[0], 1'b0, rc);
        hs_cyc[0] = rc;
        n = 0;
        while (bus.cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("spur_in_entry", bus.cfg_ready, 1'b1);
        spur_do = 16'h1234;
        spur_drdy = 1'b1;
        @(negedge clock);
        spur_drdy = 1'b0;
        checkOutput("spur_no_den", bus.drp_den, 1'b0);
        checkOutput("spur_stay_entry", bus.cfg_ready, 1'b1);
        sendEntry(seq_addr[1], seq_mask[1], seq_data[1], 1'b1, rc);
        hs_cyc[1] = rc;
        finishLock(5);
        checkLog(base, 2);
        if (log_di.size() > base + 3) checkOutput("spur_di", log_di[base+3], 16'hA5C3);

        // No drdy after the read
        resp_enable = 1'b0;
        base = log_addr.size();
        sendEntry(7'h10, 16'h00FF, 16'h1234, 1'b1, rc);
        n = 0;
        while (bus.drp_den !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        c = cyc;
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drdy_to_error", error, 1'b1);
        checkOutput("drdy_to_time", cyc - (c + 1), DRDY_TO);
        checkOutput("drdy_to_mmcm_rst", mmcm_rst, 1'b0);
        checkOutput("drdy_to_idle", busy, 1'b0);
        checkOutput("drdy_to_no_done", done, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("drdy_to_no_write", log_addr.size() - base, 1);
        checkOutput("drdy_to_err_pulse", error, 1'b0);
        resp_enable = 1'b1;

        // Locked never rises
        resp_lat = 1;
        seq_addr[0] = 7'($urandom_range(0, 127)); seq_mask[0] = 16'($urandom); seq_data[0] = 16'($urandom);
        base = log_addr.size();
        d0 = done_cnt;
        sendEntry(seq_addr[0], seq_mask[0], seq_data[0], 1'b1, rc);
        hs_cyc[0] = rc;
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        rel = cyc;
        n = 0;
        while (error !== 1'b1 && n < LOCK_TO + 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("lock_to_error", error, 1'b1);
        checkOutput("lock_to_time", cyc - rel, LOCK_TO);
        checkOutput("lock_to_idle", busy, 1'b0);
        checkOutput("lock_to_no_done", done_cnt - d0, 0);
        checkLog(base, 1);
        repeat (3) @(negedge clock);

        // Reset in WRITE_WAIT with a late drdy
        resp_lat = 2;
        seq_addr[0] = 7'($urandom_range(0, 127)); seq_mask[0] = 16'($urandom); seq_data[0] = 16'($urandom);
        base = log_addr.size();
        sendEntry(seq_addr[0], seq_mask[0], seq_data[0], 1'b1, rc);
        hs_cyc[0] = rc;
        n = 0;
        while (!(bus.drp_den === 1'b1 && bus.drp_dwe === 1'b1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        w = cyc;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid_rst_time", cyc - w, 2);
        checkOutput("mid_rst_mmcm_rst", mmcm_rst, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_ready", bus.cfg_ready, 1'b0);
        checkOutput("mid_rst_den", bus.drp_den, 1'b0);
        checkOutput("mid_rst_dwe", bus.drp_dwe, 1'b0);
        checkOutput("mid_rst_daddr", bus.drp_daddr, 7'h0);
        checkOutput("mid_rst_di", bus.drp_di, 16'h0);
        checkOutput("mid_rst_flags", {done, error}, 2'b00);
        @(negedge clock);
        checkOutput("late_drdy_idle", busy, 1'b0);
        checkOutput("late_drdy_rst", mmcm_rst, 1'b0);
        checkOutput("late_drdy_den", bus.drp_den, 1'b0);
        checkOutput("late_drdy_flags", {done, error}, 2'b00);
        checkLog(base, 1);
        repeat (3) @(negedge clock);

        // Recovery after reset
        resp_lat = $urandom_range(1, 4);
        for (int i = 0; i < 2; i++) begin
            seq_addr[i] = 7'($urandom_range(0, 127));
            seq_mask[i] = 16'($urandom);
            seq_data[i] = 16'($urandom);
        end
        applyStimulus(2, 1, 4);

        checkOutput("done_error_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
